// File: rtl/dmem_resp.sv
// Word-organised data memory with a four-state access FSM: load, word store,
// and read-merge-write byte store, plus a one-cycle completion pulse with fault flag.
module dmem_resp #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic        sb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] MERGE  = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]    state;
  logic          we_q;
  logic          sb_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   merge_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          fault;

  // Replace one little-endian byte lane of a word, keeping the other three.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  assign idx   = addr_q[AW+1:2];
  assign fault = (addr_q[31:2] >= 30'(DEPTH)) ||
                 ((addr_q[1:0] != 2'b00) && (!we_q || !sb_q));
  assign ready = (state == RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sb_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            sb_q    <= sb;
            addr_q  <= addr;
            wdata_q <= wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (fault) begin
            err   <= 1'b1;
            state <= RESP;
          end else if (!we_q) begin
            rdata <= mem[idx];
            state <= RESP;
          end else if (!sb_q) begin
            state <= RESP;
          end else begin
            merge_q <= mem[idx];
            state   <= MERGE;
          end
        end
        MERGE:   state <= RESP;
        default: begin
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Array has no reset; writes are gated by state, which reset forces to IDLE at once.
  always_ff @(posedge clk) begin
    if (state == ACCESS && !fault && we_q && !sb_q)
      mem[idx] <= wdata_q;
    else if (state == MERGE)
      mem[idx] <= merge_lane(merge_q, addr_q[1:0], wdata_q[7:0]);
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Randomised and directed bench for dmem_resp against a queue-free array model
// of memory contents, the held load result, fault rules and response latency.
module tb_dmem_resp;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        sb = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] mmem [DEPTH];
  logic [31:0] mrd = '0;

  dmem_resp #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .sb(sb),
    .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit is_fault(input logic w, input logic s, input logic [31:0] a);
    return (a / 4 >= DEPTH) || ((a % 4 != 0) && !(w && s));
  endfunction

  // Apply the access to the model: memory contents and the held load result.
  task automatic model_apply(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d);
    int i;
    int sh;
    if (is_fault(w, s, a)) return;
    i = int'(a / 4);
    if (!w) mrd = mmem[i];
    else if (!s) mmem[i] = d;
    else begin
      sh = 8 * int'(a % 4);
      mmem[i] = (mmem[i] & ~(32'hFF << sh)) | ({24'h0, d[7:0]} << sh);
    end
  endtask

  task automatic access(input string tag, input logic w, input logic s,
                        input logic [31:0] a, input logic [31:0] d);
    int  n;
    bit  got;
    int  lat;
    bit  f;
    f   = is_fault(w, s, a);
    lat = (!f && w && s) ? 3 : 2;
    @(negedge clk);
    req = 1'b1; we = w; sb = s; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'($urandom); sb = 1'($urandom); addr = $urandom; wdata = $urandom;
    n = 0; got = 0;
    while (n < 8 && !got) begin
      @(negedge clk);
      n++;
      if (ready) got = 1;
    end
    model_apply(w, s, a, d);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_err"}, {31'h0, err}, {31'h0, f});
    check({tag, "_rdata"}, rdata, mrd);
    @(negedge clk);
    check({tag, "_pulse"}, {31'h0, ready}, 32'h0);
  endtask

  initial begin
    logic [8:0] seen;
    logic [8:0] want;
    logic [31:0] a;
    logic w, s;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      mmem[i] = $urandom;
      access("init", 1'b1, 1'b0, 32'(i * 4), mmem[i]);
    end

    access("w10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    access("r10", 1'b0, 1'b0, 32'h10, 32'h0);
    check("r10_const", rdata, 32'hDEADBEEF);

    access("w20", 1'b1, 1'b0, 32'h20, 32'h11223344);
    access("sb22", 1'b1, 1'b1, 32'h22, 32'h000000AA);
    access("r20", 1'b0, 1'b0, 32'h20, 32'h0);
    check("r20_const", rdata, 32'h11AA3344);

    access("ld13", 1'b0, 1'b0, 32'h13, 32'h0);
    access("st102", 1'b1, 1'b0, 32'h102, 32'h55555555);
    access("ld100", 1'b0, 1'b0, 32'h100, 32'h0);
    access("sbhigh", 1'b1, 1'b1, 32'h103, 32'h77);
    access("r00", 1'b0, 1'b0, 32'h0, 32'h0);

    // Three loads with req held high: ready at 1, 4, 7 cycles after the first sample.
    @(negedge clk);
    req = 1'b1; we = 1'b0; sb = 1'b0; addr = 32'h20; wdata = '0;
    seen = '0; want = '0;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      seen[i] = ready;
      want[i] = (i % 3 == 1);
      if (i == 6) req = 1'b0;
    end
    model_apply(1'b0, 1'b0, 32'h20, 32'h0);
    check("b2b_pattern", {23'h0, seen}, {23'h0, want});
    check("b2b_rdata", rdata, mrd);

    // Reset during MERGE of a byte store to 0x30.
    @(negedge clk);
    req = 1'b1; we = 1'b1; sb = 1'b1; addr = 32'h31; wdata = 32'h000000C3;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    mrd = '0;
    check("rstm_ready", {31'h0, ready}, 32'h0);
    check("rstm_rdata", rdata, 32'h0);
    check("rstm_err", {31'h0, err}, 32'h0);
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen[i] = ready;
      if (i == 1) reset_n = 1'b1;
    end
    check("rstm_nopulse", {23'h0, seen}, 32'h0);
    access("rstm_r30", 1'b0, 1'b0, 32'h30, 32'h0);

    access("w40", 1'b1, 1'b0, 32'h40, 32'hCAFEF00D);
    access("r40", 1'b0, 1'b0, 32'h40, 32'h0);
    check("r40_const", rdata, 32'hCAFEF00D);

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(256, 1023));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 255));
      endcase
      w = 1'($urandom);
      s = 1'($urandom);
      if ($urandom_range(0, 3) != 0) a = (w && s) ? a : {a[31:2], 2'b00};
      access("rnd", w, s, a, $urandom);
    end

    for (int i = 0; i < DEPTH; i++) access("final", 1'b0, 1'b0, 32'(i * 4), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got %0d of %0d checks", n_pass, n_total);
    $fatal(1);
  end

endmodule
